// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle carrying a payload word and a control vector.
// The master drives valid/data/ctrl; the slave answers with ready.
interface pipe_stage_elastic_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 40
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready backpressure, flush and stall.
// SKID=1 adds a second entry so in_ready is registered with no comb path from out_ready.
module pipe_stage_elastic #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 40,
   parameter bit SKID   = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 stall,
   pipe_stage_elastic_if.slave  in_if,
   pipe_stage_elastic_if.master out_if,
   output logic [1:0]           count
);
   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] h_data_q, h_data_d, s_data_q, s_data_d;
   logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d, s_ctrl_q, s_ctrl_d;
   logic              out_valid;
   logic              do_accept;
   logic              do_release;

   assign out_valid    = (state_q != EMPTY);
   assign out_if.valid = out_valid;
   assign out_if.data  = h_data_q;
   assign out_if.ctrl  = out_valid ? h_ctrl_q : '0;
   assign count        = state_q;

   assign do_accept  = in_if.valid & in_if.ready & ~stall & ~flush;
   assign do_release = out_valid & out_if.ready & ~stall & ~flush;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      h_data_d = h_data_q;
      h_ctrl_d = h_ctrl_q;
      s_data_d = s_data_q;
      s_ctrl_d = s_ctrl_q;
      if (flush) begin
         state_d  = EMPTY;
         h_ctrl_d = '0;
         s_ctrl_d = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (do_accept) begin
                  state_d  = ONE;
                  h_data_d = in_if.data;
                  h_ctrl_d = in_if.ctrl;
               end
            end
            ONE: begin
               if (do_accept && do_release) begin
                  h_data_d = in_if.data;
                  h_ctrl_d = in_if.ctrl;
               end else if (do_release) begin
                  state_d  = EMPTY;
                  h_ctrl_d = '0;
               end else if (do_accept && SKID) begin
                  state_d  = TWO;
                  s_data_d = in_if.data;
                  s_ctrl_d = in_if.ctrl;
               end
            end
            TWO: begin
               // in_ready is low here, so the only move is the skid word sliding into the head.
               if (do_release) begin
                  state_d  = ONE;
                  h_data_d = s_data_q;
                  h_ctrl_d = s_ctrl_q;
                  s_ctrl_d = '0;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // NOTE: payload registers are reset along with control so out_data reads 0 after reset; non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= EMPTY;
         h_data_q <= '0;
         h_ctrl_q <= '0;
         s_data_q <= '0;
         s_ctrl_q <= '0;
      end else begin
         state_q  <= state_d;
         h_data_q <= h_data_d;
         h_ctrl_q <= h_ctrl_d;
         s_data_q <= s_data_d;
         s_ctrl_q <= s_ctrl_d;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic ready_q;
         // Held low through reset so the stage opens on the first edge after release.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) ready_q <= 1'b0;
            else       ready_q <= (state_d != TWO);
         end
         assign in_if.ready = ready_q;
      end else begin : g_single
         assign in_if.ready = ~out_valid | out_if.ready;
      end
   endgenerate
endmodule
